ground_manager: RTL and testbench
=================================

// Module: ground_manager
// PURPOSE
//  Owns the 16 ground-platform slots the colour mapper draws. On each frame
//  tick it scrolls every live platform left, clips or retires platforms at the
//  left screen edge, and spawns new platforms at the right edge from an LFSR.
//  The result is published as info_ground[16] in packed {len[9:0],y[8:0],x[9:0]}
//  format, which the colour mapper reads combinationally.
// PARAMETERS
//  SEED      16'hACE1  LFSR reset value; must be nonzero
//  INIT_Y    400       y of the starting floor in slot 0
//  Y_MIN     200       spawned y = Y_MIN + lfsr[15:8]  (range 200..455)
//  MIN_LEN   48        spawned len = MIN_LEN + lfsr[6:0]  (range 48..175)
//  GAP       96        minimum pixels between the previous tail and the next spawn
// PORTS
//  Clk          in   1      system clock
//  Reset_n      in   1      asynchronous reset, active low
//  vsync        in   1      frame_clk level; its rising edge is the frame tick
//  run          in   1      1 = process frame ticks; 0 = ignore ticks and hold outputs
//  speed        in   4      pixels to scroll per frame (0..15)
//  info_ground  out  29x16  published platform words, indexed [0:15]
//  active_count out  5      number of valid slots (0..16)
//  busy         out  1      high from the tick until COMMIT, inclusive
// BEHAVIOUR
//  Reset (async)
//  - Working and published copies: slot0 = {639,400,0}; slots 1-15 = EMPTY_WORD {0,511,0}.
//  - y = 511 keeps an empty slot invisible.
//  - valid = 16'h0001, tail_x (11 b) = 640, lfsr = SEED, active_count = 1.
//  - busy = 0, FSM = IDLE, vsync_q = 0.
//  Tick
//  - tick = vsync & ~vsync_q, with vsync_q registered every cycle.
//  - A tick is accepted only in IDLE with run=1. All other ticks are dropped.
//  FSM: IDLE -> SCROLL(16 cycles, slot i = 0..15) -> SPAWN(1) -> COMMIT(1) -> IDLE.
//  - busy asserts the cycle after the tick is detected. Total: 18 cycles busy.
//  SCROLL, per valid slot
//  - x >= speed: x -= speed.
//  - Otherwise clip = speed - x, then:
//    - len <= clip: retire the slot (valid = 0, word = EMPTY_WORD).
//    - Otherwise: len -= clip, x = 0.
//  - Invalid slots are untouched.
//  - tail_x is updated once in SCROLL: saturating subtract of speed, floor 0.
//  SPAWN
//  - Fires if tail_x + GAP <= 640 and a free slot exists. Lowest free index wins.
//  - New word: x = 640, y = Y_MIN + lfsr[15:8], len = MIN_LEN + lfsr[6:0].
//    These use the pre-advance lfsr value.
//  - Then: lfsr advances one step, tail_x = 640 + len, valid bit set.
//  - No free slot: skip; lfsr and tail_x unchanged. At most one spawn per frame.
//  COMMIT
//  - All 16 working words copy to info_ground in a single cycle.
//  - active_count = popcount(valid).
//  - Published outputs never change in any other state, so the mapper sees
//    atomic frame updates.
//  Arithmetic
//  - x, len are 10 bits; y is 9 bits; tail_x is 11 bits.
//  - Spawn sums never exceed 640 + 175 = 815.
//  - speed = 0: no motion and no clipping. A spawn may still occur.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11; left shift, feedback into bit 0.
//  Reset asserted mid-frame: all state returns to reset values immediately.
//  No partial frame is ever published.
// STRUCTURE
//  - ground_pkg: typedef struct packed {logic[9:0] len; logic[8:0] y;
//    logic[9:0] x;} ground_t (29 b, matches mapper bit order).
//  - ground_pkg also holds NUM_SLOTS = 16, SCREEN_W = 640, EMPTY_WORD, and
//    the state enum {IDLE, SCROLL, SPAWN, COMMIT}.
//  - Sub-module ground_lfsr: inputs Clk, Reset_n, step; output value[15:0];
//    parameter SEED.
// TESTING
//  1. Release reset, run=1, speed=4, no ticks -> slot0 = {639,400,0},
//     others = {0,511,0}, active_count = 1, busy = 0.
//  2. One vsync rise -> busy high for 18 cycles. slot0 = {635,400,0} (clip,
//     x stays 0). info_ground is unchanged until the COMMIT cycle.
//  3. 24 ticks at speed 4 -> frame 24 spawns into slot1 = {145,372,640}.
//     active_count = 2, lfsr advanced once.
//  4. 160 ticks at speed 4 -> slot0 len reaches 3 after tick 159; tick 160
//     retires it to {0,511,0}.
//  5. Second vsync rise while busy, or any rise with run=0 -> dropped; outputs
//     and lfsr are unchanged.
//  6. Assert Reset_n low during SCROLL -> outputs are at reset values in the
//     same cycle. After release, the first tick behaves exactly as in test 2.

Source files
------------

// File: rtl/ground_pkg.sv
// ground_pkg: shared types and constants for the ground-platform manager.
//   ground_t  : packed platform word {len[9:0], y[8:0], x[9:0]} (29 bits),
//               the same bit order the colour mapper decodes.
//   state_t   : frame-update FSM states.
//   popcount16: number of set bits in a 16-bit slot mask.
package ground_pkg;

  localparam int NUM_SLOTS = 16;
  localparam int SCREEN_W  = 640;

  typedef struct packed {
    logic [9:0] len;
    logic [8:0] y;
    logic [9:0] x;
  } ground_t;

  // y = 511 is below the visible area, so an empty slot never draws.
  localparam ground_t EMPTY_WORD = '{len: 10'd0, y: 9'd511, x: 10'd0};

  typedef enum logic [1:0] {
    IDLE,
    SCROLL,
    SPAWN,
    COMMIT
  } state_t;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/ground_lfsr.sv
// ground_lfsr: 16-bit Fibonacci LFSR, taps 16,14,13,11.
//   Shifts left with the feedback bit entering bit 0, one step per cycle
//   in which step is high.
// Ports:
//   Clk     in   system clock
//   Reset_n in   asynchronous reset, active low (loads SEED)
//   step    in   advance one position
//   value   out  current register contents
module ground_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        step,
  output logic [15:0] value
);

  logic feedback;

  // Tap positions 16,14,13,11 are bits 15,13,12,10.
  assign feedback = value[15] ^ value[13] ^ value[12] ^ value[10];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      value <= SEED;
    end else if (step) begin
      value <= {value[14:0], feedback};
    end
  end

endmodule

// File: rtl/ground_manager.sv
// ground_manager: owns 16 ground-platform slots. On each accepted frame tick
// it scrolls live platforms left (one slot per cycle), clips/retires platforms
// at the left edge, optionally spawns one new platform at the right edge, and
// then publishes all slots at once so the mapper only ever sees whole frames.
// Ports:
//   Clk          in   system clock
//   Reset_n      in   asynchronous reset, active low
//   vsync        in   frame clock level; rising edge = frame tick
//   run          in   1 = process ticks, 0 = ignore them
//   speed        in   scroll distance per frame in pixels
//   info_ground  out  published platform words [0:15]
//   active_count out  number of valid slots
//   busy         out  high while a frame update is in progress
module ground_manager
  import ground_pkg::*;
#(
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          INIT_Y  = 400,
  parameter int          Y_MIN   = 200,
  parameter int          MIN_LEN = 48,
  parameter int          GAP     = 96
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        vsync,
  input  logic        run,
  input  logic [3:0]  speed,
  output logic [28:0] info_ground [0:15],
  output logic [4:0]  active_count,
  output logic        busy
);

  localparam ground_t INIT_WORD = '{len: 10'(SCREEN_W - 1), y: 9'(INIT_Y), x: 10'd0};

  state_t          state_reg, state_next;
  logic [3:0]      idx_reg;
  logic            vsync_q;
  logic            tick;
  ground_t         work_reg  [NUM_SLOTS];
  ground_t         work_next [NUM_SLOTS];
  logic [15:0]     valid_reg, valid_next;
  logic [10:0]     tail_x_reg;
  logic [15:0]     lfsr_value;

  // Scroll datapath for the slot selected by idx_reg.
  ground_t         cur_word, scrolled_word;
  logic            retire;
  logic [9:0]      speed_ext, clip;
  logic [10:0]     tail_scrolled;

  // Spawn datapath.
  ground_t         new_word;
  logic [3:0]      free_idx;
  logic            free_found;
  logic            gap_ok;
  logic            spawn_fire;
  logic [10:0]     spawn_tail;

  assign tick = vsync & ~vsync_q;
  assign busy = (state_reg != IDLE);

  // ---------------- FSM ----------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (tick && run) state_next = SCROLL;
      SCROLL:  if (idx_reg == 4'd15) state_next = SPAWN;
      SPAWN:   state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- scroll ----------------
  assign speed_ext = {6'd0, speed};
  assign cur_word  = work_reg[idx_reg];

  always_comb begin
    scrolled_word = cur_word;
    retire        = 1'b0;
    clip          = 10'd0;
    if (cur_word.x >= speed_ext) begin
      scrolled_word.x = cur_word.x - speed_ext;
    end else begin
      // Part of the platform slides past x = 0: shorten it, pin x at the edge.
      clip = speed_ext - cur_word.x;
      if (cur_word.len <= clip) begin
        retire = 1'b1;
      end else begin
        scrolled_word.len = cur_word.len - clip;
        scrolled_word.x   = 10'd0;
      end
    end
  end

  assign tail_scrolled = (tail_x_reg >= {7'd0, speed}) ? tail_x_reg - {7'd0, speed} : 11'd0;

  // ---------------- spawn ----------------
  always_comb begin
    free_idx   = 4'd0;
    free_found = 1'b0;
    // Descending scan so the lowest free index is the one left standing.
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!valid_reg[i]) begin
        free_idx   = 4'(i);
        free_found = 1'b1;
      end
    end
  end

  assign new_word.x   = 10'(SCREEN_W);
  assign new_word.y   = 9'(Y_MIN) + {1'b0, lfsr_value[15:8]};
  assign new_word.len = 10'(MIN_LEN) + {3'd0, lfsr_value[6:0]};

  assign gap_ok     = ({1'b0, tail_x_reg} + 12'(GAP)) <= 12'(SCREEN_W);
  assign spawn_fire = (state_reg == SPAWN) && gap_ok && free_found;
  assign spawn_tail = 11'(SCREEN_W) + {1'b0, new_word.len};

  ground_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .step    (spawn_fire),
    .value   (lfsr_value)
  );

  // ---------------- per-slot next state ----------------
  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      logic scroll_hit;
      logic spawn_hit;
      assign scroll_hit = (state_reg == SCROLL) && (idx_reg == 4'(gi)) && valid_reg[gi];
      assign spawn_hit  = spawn_fire && (free_idx == 4'(gi));
      assign work_next[gi] = spawn_hit  ? new_word :
                             scroll_hit ? (retire ? EMPTY_WORD : scrolled_word) :
                                          work_reg[gi];
      assign valid_next[gi] = spawn_hit  ? 1'b1 :
                              scroll_hit ? ~retire :
                                           valid_reg[gi];
    end
  endgenerate

  // ---------------- working state ----------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vsync_q    <= 1'b0;
      idx_reg    <= 4'd0;
      valid_reg  <= 16'h0001;
      tail_x_reg <= 11'(SCREEN_W);
      for (int i = 0; i < NUM_SLOTS; i++) begin
        work_reg[i] <= (i == 0) ? INIT_WORD : EMPTY_WORD;
      end
    end else begin
      vsync_q   <= vsync;
      idx_reg   <= (state_reg == SCROLL) ? idx_reg + 4'd1 : 4'd0;
      valid_reg <= valid_next;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        work_reg[i] <= work_next[i];
      end
      // The tail moves once per frame; doing it on the first scroll cycle
      // keeps it ready well before the spawn decision.
      if ((state_reg == SCROLL) && (idx_reg == 4'd0)) begin
        tail_x_reg <= tail_scrolled;
      end else if (spawn_fire) begin
        tail_x_reg <= spawn_tail;
      end
    end
  end

  // ---------------- published state ----------------
  // Only written in COMMIT so the mapper never sees a half-scrolled frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      active_count <= 5'd1;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        info_ground[i] <= (i == 0) ? INIT_WORD : EMPTY_WORD;
      end
    end else if (state_reg == COMMIT) begin
      active_count <= popcount16(valid_reg);
      for (int i = 0; i < NUM_SLOTS; i++) begin
        info_ground[i] <= work_reg[i];
      end
    end
  end

endmodule

// File: tb/tb_ground_manager.sv
// tb_ground_manager: directed test of ground_manager with hand-computed
// expected platform words.
module tb_ground_manager;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        vsync;
  logic        run;
  logic [3:0]  speed;
  logic [28:0] info_ground [0:15];
  logic [4:0]  active_count;
  logic        busy;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int check_cnt = 0;
  int bad_frames = 0;

  always #5 Clk = ~Clk;

  ground_manager dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .vsync        (vsync),
    .run          (run),
    .speed        (speed),
    .info_ground  (info_ground),
    .active_count (active_count),
    .busy         (busy)
  );

  function automatic logic [28:0] w(input int len, input int y, input int x);
    logic [31:0] l, yy, xx;
    l = len; yy = y; xx = x;
    return {l[9:0], yy[8:0], xx[9:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One tick; returns busy length and count of samples where the published
  // words changed while busy was still high.
  task automatic do_frame(output int bc, output int early);
    logic [28:0] snap [0:15];
    for (int i = 0; i < 16; i++) snap[i] = info_ground[i];
    bc = 0;
    early = 0;
    @(negedge Clk); vsync = 1'b1;
    @(negedge Clk); vsync = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (busy === 1'b1) begin
        bc++;
        for (int i = 0; i < 16; i++) if (info_ground[i] !== snap[i]) early++;
      end else if (bc > 0) begin
        break;
      end
      @(negedge Clk);
    end
  endtask

  task automatic run_frames(input int n);
    int bc, early;
    for (int k = 0; k < n; k++) begin
      do_frame(bc, early);
      if (bc != 18 || early != 0) bad_frames++;
    end
  endtask

  int bc, early, busy_seen;

  initial begin
    Reset_n = 1'b0; vsync = 1'b0; run = 1'b1; speed = 4'd4;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);

    // 1: reset state
    chk("reset_slot0", info_ground[0], w(639, 400, 0));
    for (int i = 1; i < 16; i++) chk($sformatf("reset_slot%0d", i), info_ground[i], w(0, 511, 0));
    chk("reset_active", active_count, 1);
    chk("reset_busy", busy, 0);
    $display("reset checks done");

    // 2: first frame
    do_frame(bc, early);
    chk("f1_busy_len", bc, 18);
    chk("f1_early_pub", early, 0);
    chk("f1_slot0", info_ground[0], w(635, 400, 0));
    chk("f1_slot1", info_ground[1], w(0, 511, 0));
    chk("f1_active", active_count, 1);
    $display("frame 1: slot0=%h active=%0d", info_ground[0], active_count);

    // 3: first spawn at frame 24 (none at 23)
    run_frames(22);
    chk("f23_no_spawn", info_ground[1], w(0, 511, 0));
    chk("f23_active", active_count, 1);
    run_frames(1);
    chk("f24_slot1", info_ground[1], w(145, 372, 640));
    chk("f24_slot0", info_ground[0], w(543, 400, 0));
    chk("f24_active", active_count, 2);
    $display("frame 24: slot1=%h active=%0d", info_ground[1], active_count);

    // second spawn uses the once-advanced LFSR (0x59C3)
    run_frames(61);
    chk("f85_slot2", info_ground[2], w(115, 289, 640));
    chk("f85_slot1", info_ground[1], w(145, 372, 396));
    chk("f85_slot0", info_ground[0], w(299, 400, 0));
    chk("f85_active", active_count, 3);
    $display("frame 85: slot2=%h active=%0d", info_ground[2], active_count);

    run_frames(53);
    chk("f138_slot3", info_ground[3], w(55, 379, 640));
    chk("f138_active", active_count, 4);
    $display("frame 138: slot3=%h active=%0d", info_ground[3], active_count);

    // 4: slot0 retirement
    run_frames(21);
    chk("f159_slot0", info_ground[0], w(3, 400, 0));
    chk("f159_active", active_count, 4);
    run_frames(1);
    chk("f160_slot0_retired", info_ground[0], w(0, 511, 0));
    chk("f160_active", active_count, 3);
    chk("f160_slot1", info_ground[1], w(145, 372, 96));
    chk("f160_slot3", info_ground[3], w(55, 379, 552));
    chk("frames_all_18_busy", bad_frames, 0);
    $display("frame 160: slot0=%h active=%0d", info_ground[0], active_count);

    // 5a: second rise while busy is dropped
    bc = 0; busy_seen = 0;
    @(negedge Clk); vsync = 1'b1;
    @(negedge Clk); vsync = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c == 3) vsync = 1'b1;
      if (c == 4) vsync = 1'b0;
      if (busy === 1'b1) bc++;
      else if (bc > 0) break;
      @(negedge Clk);
    end
    repeat (25) begin
      @(negedge Clk);
      if (busy !== 1'b0) busy_seen++;
    end
    chk("busy_rise_len", bc, 18);
    chk("busy_rise_no_refire", busy_seen, 0);
    chk("f161_slot1", info_ground[1], w(145, 372, 92));
    $display("frame 161 with extra rise: slot1=%h", info_ground[1]);

    // 5b: run=0 ignores ticks
    run = 1'b0; busy_seen = 0;
    @(negedge Clk); vsync = 1'b1;
    @(negedge Clk); vsync = 1'b0;
    repeat (25) begin
      @(negedge Clk);
      if (busy !== 1'b0) busy_seen++;
    end
    run = 1'b1;
    chk("run0_no_busy", busy_seen, 0);
    chk("run0_slot1", info_ground[1], w(145, 372, 92));
    chk("run0_active", active_count, 3);
    $display("run=0 tick: slot1=%h active=%0d", info_ground[1], active_count);

    // 6: reset during SCROLL
    @(negedge Clk); vsync = 1'b1;
    @(negedge Clk); vsync = 1'b0;
    repeat (4) @(negedge Clk);
    chk("pre_reset_busy", busy, 1);
    Reset_n = 1'b0;
    #1;
    chk("midrst_slot0", info_ground[0], w(639, 400, 0));
    chk("midrst_slot1", info_ground[1], w(0, 511, 0));
    chk("midrst_active", active_count, 1);
    chk("midrst_busy", busy, 0);
    @(negedge Clk); @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    do_frame(bc, early);
    chk("post_rst_busy_len", bc, 18);
    chk("post_rst_slot0", info_ground[0], w(635, 400, 0));
    chk("post_rst_active", active_count, 1);
    $display("after mid-frame reset: slot0=%h", info_ground[0]);

    // speed 0: no motion or clipping
    speed = 4'd0;
    do_frame(bc, early);
    chk("speed0_slot0", info_ground[0], w(635, 400, 0));
    chk("speed0_slot1", info_ground[1], w(0, 511, 0));
    $display("speed 0 frame: slot0=%h", info_ground[0]);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
